// File: rtl/hack_pkg.sv
// Shared definitions for the multi-cycle Hack CPU: FSM states, instruction
// field positions, jump codes and the minimum supported data width.
package hack_pkg;

    localparam int MIN_WIDTH = 16;

    // C-instruction field positions (fixed, independent of WIDTH)
    localparam int BIT_A   = 12;
    localparam int COMP_HI = 11;
    localparam int COMP_LO = 6;
    localparam int BIT_DA  = 5;
    localparam int BIT_DD  = 4;
    localparam int BIT_DM  = 3;
    localparam int JUMP_HI = 2;
    localparam int JUMP_LO = 0;

    // comp sub-field positions inside the 6-bit comp field
    localparam int COMP_ZX = 5;
    localparam int COMP_NX = 4;
    localparam int COMP_ZY = 3;
    localparam int COMP_NY = 2;
    localparam int COMP_F  = 1;
    localparam int COMP_NO = 0;

    localparam logic [2:0] JMP_NONE   = 3'b000;
    localparam logic [2:0] JMP_ALWAYS = 3'b111;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        HALT = 2'd3
    } cpuState_t;

    function automatic bit widthOk(int w);
        return w >= MIN_WIDTH;
    endfunction

    // Registered handshake flags per state: {inst_ready, readM, writeM, halted}
    function automatic logic [3:0] stateFlags(cpuState_t s);
        case (s)
            RUN:     return 4'b1000;
            RD:      return 4'b0100;
            WR:      return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

endpackage

// File: rtl/hack_cpu_mc_alu.sv
// Combinational Hack ALU: x/y zero and negate controls, add or and, output negate,
// plus zero and negative flags on the WIDTH-bit result.
module hack_alu
    import hack_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       comp,
    output logic [WIDTH-1:0] result,
    output logic             zr,
    output logic             ng
);

    logic [WIDTH-1:0] xz;
    logic [WIDTH-1:0] xn;
    logic [WIDTH-1:0] yz;
    logic [WIDTH-1:0] yn;
    logic [WIDTH-1:0] fOut;

    always_comb begin
        xz     = comp[COMP_ZX] ? '0 : x;
        xn     = comp[COMP_NX] ? ~xz : xz;
        yz     = comp[COMP_ZY] ? '0 : y;
        yn     = comp[COMP_NY] ? ~yz : yz;
        fOut   = comp[COMP_F] ? (xn + yn) : (xn & yn);
        result = comp[COMP_NO] ? ~fOut : fOut;
    end

    assign zr = (result == '0);
    assign ng = result[WIDTH-1];

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: single-cycle register instructions, RD/WR states for
// memory operands with a mem_ready handshake, and a self-jump HALT detector.
module hack_cpu_mc
    import hack_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int AW = WIDTH - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] inst,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic [WIDTH-1:0] inM,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] outM,
    output logic             writeM,
    output logic             readM,
    output logic [AW-1:0]    addressM,
    output logic [AW-1:0]    pc,
    output logic             halted,
    output logic [1:0]       dbgState
);

    if (!widthOk(WIDTH)) begin : gBadWidth
        $error("hack_cpu_mc: WIDTH must be at least %0d", MIN_WIDTH);
    end

    localparam logic [AW-1:0] PC_ONE = AW'(1);

    // Handshakes: an instruction transfers on a rising edge where inst_valid and
    // inst_ready are both high; a memory access (readM or writeM high) finishes on
    // the rising edge where mem_ready is high, and mem_ready is ignored otherwise.
    cpuState_t        state;
    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] regD;
    logic [WIDTH-1:0] instQ;
    logic [WIDTH-1:0] inMQ;
    logic [WIDTH-1:0] curInst;
    logic [WIDTH-1:0] yOp;
    logic [WIDTH-1:0] aluOut;
    logic             aluZr;
    logic             aluNg;
    logic             isC;
    logic             aBit;
    logic             destA;
    logic             destD;
    logic             destM;
    logic [2:0]       jump;
    logic             jumpTaken;
    logic             haltNow;
    logic             completeNow;
    logic [AW-1:0]    pcNext;
    cpuState_t        doneState;

    // In RUN the incoming word is decoded directly; later states use the latched copy.
    assign curInst = (state == RUN) ? inst : instQ;
    assign isC     = curInst[WIDTH-1];
    assign aBit    = curInst[BIT_A];
    assign destA   = curInst[BIT_DA];
    assign destD   = curInst[BIT_DD];
    assign destM   = curInst[BIT_DM];
    assign jump    = curInst[JUMP_HI:JUMP_LO];

    // During the RD completion edge the operand is the word being latched now.
    assign yOp = !aBit ? regA : ((state == RD) ? inM : inMQ);

    hack_alu #(.WIDTH(WIDTH)) uAlu (
        .x      (regD),
        .y      (yOp),
        .comp   (curInst[COMP_HI:COMP_LO]),
        .result (aluOut),
        .zr     (aluZr),
        .ng     (aluNg)
    );

    assign jumpTaken = (jump[2] & aluNg) | (jump[1] & aluZr) | (jump[0] & ~aluNg & ~aluZr);
    assign pcNext    = jumpTaken ? regA[AW-1:0] : (pc + PC_ONE);
    assign haltNow   = (jump == JMP_ALWAYS) && (regA[AW-1:0] == pc);
    assign doneState = haltNow ? HALT : RUN;

    always_comb begin
        completeNow = 1'b0;
        case (state)
            RUN:     completeNow = inst_valid && isC && !aBit && !destM;
            RD:      completeNow = mem_ready && !destM;
            WR:      completeNow = mem_ready;
            default: completeNow = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            regA  <= '0;
            regD  <= '0;
            pc    <= '0;
            outM  <= '0;
            instQ <= '0;
            inMQ  <= '0;
            {inst_ready, readM, writeM, halted} <= stateFlags(RUN);
        end else begin
            case (state)
                RUN: begin
                    if (inst_valid) begin
                        if (!isC) begin
                            regA <= {1'b0, curInst[AW-1:0]};
                            pc   <= pc + PC_ONE;
                        end else begin
                            instQ <= inst;
                            if (aBit) begin
                                state <= RD;
                                {inst_ready, readM, writeM, halted} <= stateFlags(RD);
                            end else if (destM) begin
                                outM  <= aluOut;
                                state <= WR;
                                {inst_ready, readM, writeM, halted} <= stateFlags(WR);
                            end
                        end
                    end
                end
                RD: begin
                    if (mem_ready) begin
                        inMQ <= inM;
                        if (destM) begin
                            outM  <= aluOut;
                            state <= WR;
                            {inst_ready, readM, writeM, halted} <= stateFlags(WR);
                        end
                    end
                end
                default: ;
            endcase

            // A and D keep their old values until the whole instruction retires.
            if (completeNow) begin
                if (destA) regA <= aluOut;
                if (destD) regD <= aluOut;
                pc    <= pcNext;
                state <= doneState;
                {inst_ready, readM, writeM, halted} <= stateFlags(doneState);
            end
        end
    end

    assign addressM = regA[AW-1:0];
    assign dbgState = state;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc: a per-cycle vector table for the 16-bit core,
// hand-written reset, halt and 24-bit jump sequences, and a memory write scoreboard.
module tb_hack_cpu_mc;

    localparam logic [3:0] F_RUN  = 4'b1000;
    localparam logic [3:0] F_RD   = 4'b0100;
    localparam logic [3:0] F_WR   = 4'b0010;
    localparam logic [3:0] F_HALT = 4'b0001;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [15:0] inst16;
    logic        valid16;
    logic        ready16;
    logic [15:0] inM16;
    logic        mr16;
    logic [15:0] outM16;
    logic        wr16;
    logic        rd16;
    logic [14:0] addr16;
    logic [14:0] pc16;
    logic        halt16;
    logic [1:0]  dbg16;

    logic [23:0] inst24;
    logic        valid24;
    logic        ready24;
    logic [23:0] inM24;
    logic        mr24;
    logic [23:0] outM24;
    logic        wr24;
    logic        rd24;
    logic [22:0] addr24;
    logic [22:0] pc24;
    logic        halt24;
    logic [1:0]  dbg24;

    hack_cpu_mc #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .inst(inst16), .inst_valid(valid16), .inst_ready(ready16),
        .inM(inM16), .mem_ready(mr16), .outM(outM16), .writeM(wr16), .readM(rd16),
        .addressM(addr16), .pc(pc16), .halted(halt16), .dbgState(dbg16)
    );

    hack_cpu_mc #(.WIDTH(24)) dut24 (
        .clk(clk), .reset(reset), .inst(inst24), .inst_valid(valid24), .inst_ready(ready24),
        .inM(inM24), .mem_ready(mr24), .outM(outM24), .writeM(wr24), .readM(rd24),
        .addressM(addr24), .pc(pc24), .halted(halt24), .dbgState(dbg24)
    );

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] inst;
        logic        valid;
        logic        memReady;
        logic [15:0] inM;
        logic [14:0] addr;
        logic [14:0] pc;
        logic [3:0]  flags;
        logic [15:0] outM;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [15:0] i, logic v, logic m, logic [15:0] d,
                                logic [14:0] a, logic [14:0] p, logic [3:0] f, logic [15:0] o);
        vec_t r;
        r.inst = i; r.valid = v; r.memReady = m; r.inM = d;
        r.addr = a; r.pc = p; r.flags = f; r.outM = o;
        return r;
    endfunction

    // Scoreboard of expected memory writes: {address, data}
    logic [30:0] expQ[$];

    always @(negedge clk) begin
        if (reset) begin
            check("rd_wr_exclusive", 32'(rd16 & wr16), 32'd0);
            if (wr16 && mr16) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL write_unexpected: got write 0x%0h to 0x%0h, expected none", outM16, addr16);
                end else begin
                    check("write_addr_data", {1'b0, addr16, outM16}, {1'b0, expQ.pop_front()});
                end
            end
        end
    end

    task automatic step24(input string name, input logic [23:0] i, input logic [22:0] a, input logic [22:0] p);
        inst24  = i;
        valid24 = 1'b1;
        tick();
        check({name, " addr"}, 32'(addr24), 32'(a));
        check({name, " pc"}, 32'(pc24), 32'(p));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1);
    end

    initial begin
        reset   = 1'b0;
        inst16  = '0; valid16 = 1'b0; inM16 = '0; mr16 = 1'b0;
        inst24  = '0; valid24 = 1'b0; inM24 = '0; mr24 = 1'b0;

        expQ.push_back({15'd1000, 16'd12345});
        expQ.push_back({15'd1000, 16'd11112});
        expQ.push_back({15'd1000, 16'd777});
        expQ.push_back({15'd42,   16'd0});

        //                 inst     v     mr    inM         addr        pc         flags   outM
        vecs.push_back(mk(16'h3039, 1'b1, 1'b0, 16'd0,     15'd12345, 15'd1,     F_RUN,  16'd0));
        vecs.push_back(mk(16'hEC10, 1'b1, 1'b1, 16'd0,     15'd12345, 15'd2,     F_RUN,  16'd0));
        vecs.push_back(mk(16'h03E8, 1'b1, 1'b0, 16'd0,     15'd1000,  15'd3,     F_RUN,  16'd0));
        vecs.push_back(mk(16'hE308, 1'b1, 1'b0, 16'd0,     15'd1000,  15'd3,     F_WR,   16'd12345));
        vecs.push_back(mk(16'h0007, 1'b1, 1'b0, 16'd0,     15'd1000,  15'd3,     F_WR,   16'd12345));
        vecs.push_back(mk(16'h0007, 1'b1, 1'b0, 16'd0,     15'd1000,  15'd3,     F_WR,   16'd12345));
        vecs.push_back(mk(16'h0000, 1'b0, 1'b1, 16'd0,     15'd1000,  15'd4,     F_RUN,  16'd12345));
        vecs.push_back(mk(16'h03E8, 1'b1, 1'b0, 16'd0,     15'd1000,  15'd5,     F_RUN,  16'd12345));
        vecs.push_back(mk(16'hFDC8, 1'b1, 1'b0, 16'd0,     15'd1000,  15'd5,     F_RD,   16'd12345));
        vecs.push_back(mk(16'h0000, 1'b0, 1'b0, 16'd11111, 15'd1000,  15'd5,     F_RD,   16'd12345));
        vecs.push_back(mk(16'h0000, 1'b0, 1'b1, 16'd11111, 15'd1000,  15'd5,     F_WR,   16'd11112));
        vecs.push_back(mk(16'h0000, 1'b0, 1'b1, 16'd0,     15'd1000,  15'd6,     F_RUN,  16'd11112));
        vecs.push_back(mk(16'hFFFF, 1'b0, 1'b1, 16'd0,     15'd1000,  15'd6,     F_RUN,  16'd11112));
        vecs.push_back(mk(16'hFFFF, 1'b0, 1'b1, 16'd0,     15'd1000,  15'd6,     F_RUN,  16'd11112));
        vecs.push_back(mk(16'hFFFF, 1'b0, 1'b1, 16'd0,     15'd1000,  15'd6,     F_RUN,  16'd11112));
        vecs.push_back(mk(16'hFC10, 1'b1, 1'b0, 16'd0,     15'd1000,  15'd6,     F_RD,   16'd11112));
        vecs.push_back(mk(16'h0000, 1'b0, 1'b1, 16'd777,   15'd1000,  15'd7,     F_RUN,  16'd11112));
        vecs.push_back(mk(16'hE308, 1'b1, 1'b0, 16'd0,     15'd1000,  15'd7,     F_WR,   16'd777));
        vecs.push_back(mk(16'h0000, 1'b0, 1'b1, 16'd0,     15'd1000,  15'd8,     F_RUN,  16'd777));
        vecs.push_back(mk(16'h7FFF, 1'b1, 1'b0, 16'd0,     15'd32767, 15'd9,     F_RUN,  16'd777));
        vecs.push_back(mk(16'hEE90, 1'b1, 1'b0, 16'd0,     15'd32767, 15'd10,    F_RUN,  16'd777));
        vecs.push_back(mk(16'h000E, 1'b1, 1'b0, 16'd0,     15'd14,    15'd11,    F_RUN,  16'd777));
        vecs.push_back(mk(16'hE304, 1'b1, 1'b0, 16'd0,     15'd14,    15'd14,    F_RUN,  16'd777));
        vecs.push_back(mk(16'hE301, 1'b1, 1'b0, 16'd0,     15'd14,    15'd15,    F_RUN,  16'd777));
        vecs.push_back(mk(16'hE302, 1'b1, 1'b0, 16'd0,     15'd14,    15'd16,    F_RUN,  16'd777));
        vecs.push_back(mk(16'h7FFF, 1'b1, 1'b0, 16'd0,     15'd32767, 15'd17,    F_RUN,  16'd777));
        vecs.push_back(mk(16'hEA87, 1'b1, 1'b0, 16'd0,     15'd32767, 15'd32767, F_RUN,  16'd777));
        vecs.push_back(mk(16'h0005, 1'b1, 1'b0, 16'd0,     15'd5,     15'd0,     F_RUN,  16'd777));
        vecs.push_back(mk(16'h0005, 1'b1, 1'b0, 16'd0,     15'd5,     15'd1,     F_RUN,  16'd777));
        vecs.push_back(mk(16'h0005, 1'b1, 1'b0, 16'd0,     15'd5,     15'd2,     F_RUN,  16'd777));
        vecs.push_back(mk(16'h0005, 1'b1, 1'b0, 16'd0,     15'd5,     15'd3,     F_RUN,  16'd777));
        vecs.push_back(mk(16'h0005, 1'b1, 1'b0, 16'd0,     15'd5,     15'd4,     F_RUN,  16'd777));
        vecs.push_back(mk(16'h0005, 1'b1, 1'b0, 16'd0,     15'd5,     15'd5,     F_RUN,  16'd777));
        vecs.push_back(mk(16'hEA87, 1'b1, 1'b0, 16'd0,     15'd5,     15'd5,     F_HALT, 16'd777));
        vecs.push_back(mk(16'h0009, 1'b1, 1'b1, 16'd0,     15'd5,     15'd5,     F_HALT, 16'd777));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset addr16", 32'(addr16), 32'd0);
        check("reset pc16", 32'(pc16), 32'd0);
        check("reset flags16", 32'({ready16, rd16, wr16, halt16}), 32'(F_RUN));
        check("reset outM16", 32'(outM16), 32'd0);
        check("reset state16", 32'(dbg16), 32'd0);
        check("reset pc24", 32'(pc24), 32'd0);
        check("reset flags24", 32'({ready24, rd24, wr24, halt24}), 32'(F_RUN));
        check("reset state24", 32'(dbg24), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            inst16  = vecs[i].inst;
            valid16 = vecs[i].valid;
            mr16    = vecs[i].memReady;
            inM16   = vecs[i].inM;
            tick();
            check($sformatf("row%0d addr", i), 32'(addr16), 32'(vecs[i].addr));
            check($sformatf("row%0d pc", i), 32'(pc16), 32'(vecs[i].pc));
            check($sformatf("row%0d flags", i), 32'({ready16, rd16, wr16, halt16}), 32'(vecs[i].flags));
            check($sformatf("row%0d outM", i), 32'(outM16), 32'(vecs[i].outM));
        end

        // Reset pulse leaves HALT asynchronously
        inst16 = '0; valid16 = 1'b0; mr16 = 1'b0; inM16 = '0;
        reset = 1'b0;
        #2;
        check("halt_reset halted", 32'(halt16), 32'd0);
        check("halt_reset pc", 32'(pc16), 32'd0);
        check("halt_reset flags", 32'({ready16, rd16, wr16, halt16}), 32'(F_RUN));
        tick();
        reset = 1'b1;

        // Reset during a pending read abandons it
        inst16 = 16'h0064; valid16 = 1'b1;
        tick();
        check("rd_abort setup addr", 32'(addr16), 32'd100);
        check("rd_abort setup pc", 32'(pc16), 32'd1);
        inst16 = 16'hFC10;
        tick();
        check("rd_abort enter flags", 32'({ready16, rd16, wr16, halt16}), 32'(F_RD));
        valid16 = 1'b0;
        tick();
        check("rd_abort hold flags", 32'({ready16, rd16, wr16, halt16}), 32'(F_RD));
        check("rd_abort hold pc", 32'(pc16), 32'd1);
        inM16 = 16'd5; mr16 = 1'b1; reset = 1'b0;
        #2;
        check("rd_abort reset flags", 32'({ready16, rd16, wr16, halt16}), 32'(F_RUN));
        check("rd_abort reset pc", 32'(pc16), 32'd0);
        check("rd_abort reset addr", 32'(addr16), 32'd0);
        tick();
        reset = 1'b1; mr16 = 1'b0;
        tick();
        check("rd_abort idle pc", 32'(pc16), 32'd0);
        check("rd_abort idle flags", 32'({ready16, rd16, wr16, halt16}), 32'(F_RUN));
        inst16 = 16'd42; valid16 = 1'b1;
        tick();
        check("rd_abort fetch addr", 32'(addr16), 32'd42);
        check("rd_abort fetch pc", 32'(pc16), 32'd1);
        inst16 = 16'hE308;
        tick();
        check("rd_abort D clear flags", 32'({ready16, rd16, wr16, halt16}), 32'(F_WR));
        check("rd_abort D clear outM", 32'(outM16), 32'd0);
        valid16 = 1'b0; mr16 = 1'b1;
        tick();
        check("rd_abort write done pc", 32'(pc16), 32'd2);
        check("rd_abort write done flags", 32'({ready16, rd16, wr16, halt16}), 32'(F_RUN));
        mr16 = 1'b0;

        // 24-bit core: decode on bit 23 and sign on bit 23
        step24("w24 D=-1", 24'h800E90, 23'd0, 23'd1);
        step24("w24 A-inst", 24'h00E304, 23'h00E304, 23'd2);
        step24("w24 @14", 24'h00000E, 23'd14, 23'd3);
        step24("w24 JLT", 24'h800304, 23'd14, 23'd14);
        step24("w24 JGT", 24'h800301, 23'd14, 23'd15);
        valid24 = 1'b0;
        tick();
        check("w24 flags", 32'({ready24, rd24, wr24, halt24}), 32'(F_RUN));

        check("write_queue_empty", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
